// File: rtl/csr_pkg.sv
// Shared CSR definitions: op codes, machine-mode CSR addresses, exception codes,
// controller FSM states and the legal-CSR check used by CSR requesters.
package csr_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_RW    = 3'd1,
      OP_RS    = 3'd2,
      OP_RC    = 3'd3,
      OP_ECALL = 3'd4,
      OP_MRET  = 3'd5
   } csr_op_t;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [3:0] ECODE_ECALL_M = 4'd11;
   localparam logic [3:0] ECODE_ILLEGAL = 4'd2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_EXEC  = 3'd1,
      ST_TRAP  = 3'd2,
      ST_ENTRY = 3'd3,
      ST_RET   = 3'd4,
      ST_RESP  = 3'd5
   } csr_state_t;

   function automatic logic csr_is_legal(input logic [11:0] num);
      return (num == CSR_MSTATUS) || (num == CSR_MTVEC) ||
             (num == CSR_MEPC)    || (num == CSR_MCAUSE);
   endfunction

endpackage

// File: rtl/csr_access_ctrl_if.sv
// Signal bundle between the execute stage / CSR register block (master) and the
// CSR access controller (slave).
// Handshakes (in_valid/in_ready, out_valid/out_ready): a transfer happens on a clock
// edge where valid and ready are both high; the sender keeps valid and its payload
// stable until that edge, and ready never depends on anything but controller state.
interface csr_access_ctrl_if #(
   parameter int XLEN    = 64,
   parameter int ECODE_W = 63
);
   logic               in_valid;
   logic               in_ready;
   logic [2:0]         in_op;
   logic               in_use_imm;
   logic [4:0]         in_zimm;
   logic [XLEN-1:0]    in_rs1;
   logic [4:0]         in_rd;
   logic [11:0]        in_csr;
   logic [XLEN-1:0]    in_pc;

   logic               out_valid;
   logic               out_ready;
   logic               out_rd_wen;
   logic [4:0]         out_rd;
   logic [XLEN-1:0]    out_rd_data;
   logic               out_redirect;
   logic [XLEN-1:0]    out_redirect_pc;

   logic               csr_re;
   logic [11:0]        csr_num;
   logic               csr_we;
   logic [XLEN-1:0]    csr_wmask;
   logic [XLEN-1:0]    csr_wvalue;
   logic [XLEN-1:0]    csr_rvalue;
   logic               ex;
   logic [XLEN-1:0]    epc;
   logic [ECODE_W-1:0] ecode;
   logic               ex_ret;
   logic [XLEN-1:0]    ex_entry;

   modport master (
      output in_valid, in_op, in_use_imm, in_zimm, in_rs1, in_rd, in_csr, in_pc,
      output out_ready, csr_rvalue, ex_entry,
      input  in_ready, out_valid, out_rd_wen, out_rd, out_rd_data, out_redirect,
      input  out_redirect_pc, csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
      input  ex, epc, ecode, ex_ret
   );

   modport slave (
      input  in_valid, in_op, in_use_imm, in_zimm, in_rs1, in_rd, in_csr, in_pc,
      input  out_ready, csr_rvalue, ex_entry,
      output in_ready, out_valid, out_rd_wen, out_rd, out_rd_data, out_redirect,
      output out_redirect_pc, csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
      output ex, epc, ecode, ex_ret
   );
endinterface

// File: rtl/csr_wmask_gen.sv
// Turns a CSR op and its source operand into the write strobe, bit mask and value
// seen by the CSR file; set/clear with a zero source must not write at all.
module csr_wmask_gen
   import csr_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src,
   output logic            we,
   output logic [XLEN-1:0] wmask,
   output logic [XLEN-1:0] wvalue
);

   always_comb begin
      we     = 1'b0;
      wmask  = '0;
      wvalue = '0;
      case (op)
         OP_RW: begin
            we     = 1'b1;
            wmask  = '1;
            wvalue = src;
         end
         OP_RS: begin
            we     = (src != '0);
            wmask  = src;
            wvalue = '1;
         end
         OP_RC: begin
            we     = (src != '0);
            wmask  = src;
            wvalue = '0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequences one CSR/system instruction at a time into CSR or trap/return strobes.
// Optional: define CSR_ACCESS_CTRL_ILLEGAL_TRAP_EN to trap reserved ops / unknown CSRs.
module csr_access_ctrl
   import csr_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int ECODE_W = 63
) (
   input  logic                clk,
   input  logic                rst,
   csr_access_ctrl_if.slave    bus,
   output csr_state_t          dbg_state
);

`ifdef CSR_ACCESS_CTRL_ILLEGAL_TRAP_EN
   localparam csr_state_t ILLEGAL_NEXT = ST_TRAP;
`else
   localparam csr_state_t ILLEGAL_NEXT = ST_RESP;
`endif

   csr_state_t      state_q, state_d, decode_state;
   logic [3:0]      decode_ecode;
   logic [2:0]      op_q;
   logic [XLEN-1:0] src_q;
   logic [4:0]      rd_q;
   logic [11:0]     csr_q;
   logic [XLEN-1:0] pc_q;
   logic [3:0]      ecode_q;
   logic            rd_wen_q;
   logic [XLEN-1:0] rd_data_q;
   logic            redirect_q;
   logic [XLEN-1:0] redirect_pc_q;
   logic            gen_we;
   logic [XLEN-1:0] gen_wmask, gen_wvalue;

   csr_wmask_gen #(.XLEN(XLEN)) u_wmask_gen (
      .op     (op_q),
      .src    (src_q),
      .we     (gen_we),
      .wmask  (gen_wmask),
      .wvalue (gen_wvalue)
   );

   always_comb begin
      decode_state = ILLEGAL_NEXT;
      decode_ecode = ECODE_ILLEGAL;
      case (bus.in_op)
         OP_NOP:               decode_state = ST_RESP;
         OP_RW, OP_RS, OP_RC:  decode_state = csr_is_legal(bus.in_csr) ? ST_EXEC : ILLEGAL_NEXT;
         OP_ECALL: begin
            decode_state = ST_TRAP;
            decode_ecode = ECODE_ECALL_M;
         end
         OP_MRET:              decode_state = ST_RET;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      bus.in_ready   = 1'b0;
      bus.out_valid  = 1'b0;
      bus.csr_re     = 1'b0;
      bus.csr_num    = '0;
      bus.csr_we     = 1'b0;
      bus.csr_wmask  = '0;
      bus.csr_wvalue = '0;
      bus.ex         = 1'b0;
      bus.epc        = '0;
      bus.ecode      = '0;
      bus.ex_ret     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_d = decode_state;
         end
         // Read and write share the cycle: the CSR file commits on this edge, so the
         // value captured here is still the old one.
         ST_EXEC: begin
            bus.csr_re     = 1'b1;
            bus.csr_num    = csr_q;
            bus.csr_we     = gen_we;
            bus.csr_wmask  = gen_wmask;
            bus.csr_wvalue = gen_wvalue;
            state_d        = ST_RESP;
         end
         ST_TRAP: begin
            bus.ex    = 1'b1;
            bus.epc   = pc_q;
            bus.ecode = {{(ECODE_W-4){1'b0}}, ecode_q};
            state_d   = ST_ENTRY;
         end
         ST_ENTRY: state_d = ST_RESP;
         ST_RET: begin
            bus.ex_ret = 1'b1;
            state_d    = ST_RESP;
         end
         ST_RESP: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q          <= '0;
         src_q         <= '0;
         rd_q          <= '0;
         csr_q         <= '0;
         pc_q          <= '0;
         ecode_q       <= '0;
         rd_wen_q      <= 1'b0;
         rd_data_q     <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (bus.in_valid) begin
               op_q          <= bus.in_op;
               src_q         <= bus.in_use_imm ? {{(XLEN-5){1'b0}}, bus.in_zimm} : bus.in_rs1;
               rd_q          <= bus.in_rd;
               csr_q         <= bus.in_csr;
               pc_q          <= bus.in_pc;
               ecode_q       <= decode_ecode;
               rd_wen_q      <= 1'b0;
               rd_data_q     <= '0;
               redirect_q    <= 1'b0;
               redirect_pc_q <= '0;
            end
            ST_EXEC: begin
               rd_data_q <= bus.csr_rvalue;
               rd_wen_q  <= (rd_q != 5'd0);
            end
            // mcause/mepc were written on the previous edge, so mtvec is current here.
            ST_ENTRY: begin
               redirect_pc_q <= bus.ex_entry;
               redirect_q    <= 1'b1;
            end
            ST_RET: begin
               redirect_pc_q <= bus.csr_rvalue;
               redirect_q    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.out_rd_wen      = rd_wen_q;
   assign bus.out_rd          = rd_q;
   assign bus.out_rd_data     = rd_data_q;
   assign bus.out_redirect    = redirect_q;
   assign bus.out_redirect_pc = redirect_pc_q;
   assign dbg_state           = state_q;

endmodule
